// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT defaults, reorder FSM states and a runtime-k bit reverser.
package fft_pkg;
  localparam int LOG2N_MAX_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int REV_W = 16;
  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_READ, S_WAIT, S_WRITE, S_DONE} state_e;
  // Full-width reverse then shift down: the low k bits of v land reversed at the bottom.
  function automatic logic [REV_W-1:0] bit_rev(input logic [REV_W-1:0] v, input logic [4:0] k);
    logic [REV_W-1:0] r;
    for (int b = 0; b < REV_W; b++) r[b] = v[REV_W-1-b];
    return r >> (REV_W - int'(k));
  endfunction
endpackage

// File: rtl/bit_rev_addr.sv
// bit_rev_addr: combinational reverse of the low k_i bits of an address; upper bits read as 0.
module bit_rev_addr import fft_pkg::*; #(
  parameter int W = LOG2N_MAX_DEF
) (
  input  logic [W-1:0]             a_i,
  input  logic [$clog2(W+1)-1:0]   k_i,
  output logic [W-1:0]             r_o
);
  assign r_o = W'(bit_rev(REV_W'(a_i), 5'(k_i)));
endmodule

// File: rtl/bit_rev_reorder_engine.sv
// bit_rev_reorder_engine: in-place bit-reversal reorder of a dual-port sample RAM.
// Swaps each (i, rev(i)) with i < rev(i); all RAM-facing outputs are registered.
module bit_rev_reorder_engine import fft_pkg::*; #(
  parameter int LOG2N_MAX = LOG2N_MAX_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RD_LAT    = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic [$clog2(LOG2N_MAX+1)-1:0]   size_log2_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             size_err_o,
  output logic [LOG2N_MAX-1:0]             addr_a_o,
  output logic [LOG2N_MAX-1:0]             addr_b_o,
  output logic [DATA_W-1:0]                din_a_o,
  output logic [DATA_W-1:0]                din_b_o,
  output logic                             we_a_o,
  output logic                             we_b_o,
  input  logic [DATA_W-1:0]                dout_a_i,
  input  logic [DATA_W-1:0]                dout_b_i
);
  localparam int KW = $clog2(LOG2N_MAX+1);
  state_e state_q, state_d;
  logic [LOG2N_MAX-1:0] i_q, i_d, rev_w, last_w, addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [KW-1:0] k_q, k_d;
  logic [1:0] cnt_q, cnt_d;
  logic err_q, err_d, busy_q, busy_d, done_q, done_d, we_q, we_d, over_w, zero_w, port_w;
  logic [DATA_W-1:0] ta_q, ta_d, tb_q, tb_d;

  bit_rev_addr #(.W(LOG2N_MAX)) u_rev (.a_i(i_q), .k_i(k_q), .r_o(rev_w));

  assign last_w = {LOG2N_MAX{1'b1}} >> (LOG2N_MAX - int'(k_q));
  assign over_w = size_log2_i > KW'(LOG2N_MAX);
  assign zero_w = size_log2_i == '0;

  always_comb begin
    state_d = state_q;
    i_d = i_q;
    k_d = k_q;
    cnt_d = cnt_q;
    err_d = err_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        k_d = over_w ? KW'(LOG2N_MAX) : zero_w ? KW'(1) : size_log2_i;
        err_d = over_w || zero_w;
        i_d = '0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        state_d = (i_q < rev_w) ? S_READ : (i_q == last_w) ? S_DONE : S_SCAN;
        i_d = (i_q < rev_w || i_q == last_w) ? i_q : i_q + 1'b1;
      end
      S_READ: begin
        cnt_d = 2'(RD_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? S_WRITE : S_WAIT;
      end
      S_WRITE: begin
        i_d = i_q + 1'b1;
        state_d = S_SCAN;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs are computed from the next state so they appear registered in that state.
    port_w = state_d inside {S_READ, S_WAIT, S_WRITE};
    we_d = state_d == S_WRITE;
    addr_a_d = port_w ? i_q : '0;
    addr_b_d = port_w ? rev_w : '0;
    ta_d = we_d ? dout_a_i : '0;
    tb_d = we_d ? dout_b_i : '0;
    busy_d = state_d inside {S_SCAN, S_READ, S_WAIT, S_WRITE};
    done_d = state_d == S_DONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      i_q <= '0;
      k_q <= KW'(1);
      cnt_q <= '0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      we_q <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      ta_q <= '0;
      tb_q <= '0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      k_q <= k_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      busy_q <= busy_d;
      done_q <= done_d;
      we_q <= we_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      ta_q <= ta_d;
      tb_q <= tb_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign size_err_o = err_q;
  assign addr_a_o = addr_a_q;
  assign addr_b_o = addr_b_q;
  assign din_a_o = tb_q;
  assign din_b_o = ta_q;
  assign we_a_o = we_q;
  assign we_b_o = we_q;
endmodule

// File: tb/tb_bit_rev_reorder_engine.sv
// tb_bit_rev_reorder_engine: runs RD_LAT=1 and RD_LAT=2 engines side by side on private RAM
// models and checks RAM contents, timing and handshakes against a plain permutation model.
module tb_bit_rev_reorder_engine;
  localparam int L = 8, DW = 32;
  logic clk = 0, rst_n = 1, start = 0, ld = 0;
  logic [3:0] size = 0;
  logic busy[2], done[2], err[2], we_a[2], we_b[2];
  logic [L-1:0] addr_a[2], addr_b[2];
  logic [DW-1:0] din_a[2], din_b[2], dout_a[2], dout_b[2], pa[2], pb[2], qa[2], qb[2];
  logic [DW-1:0] mem[2][256], init[256];
  int bc[2], dc[2], wc[2], bad[2];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bit_rev_reorder_engine #(.LOG2N_MAX(L), .DATA_W(DW), .RD_LAT(g + 1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .size_log2_i(size),
      .busy_o(busy[g]), .done_o(done[g]), .size_err_o(err[g]),
      .addr_a_o(addr_a[g]), .addr_b_o(addr_b[g]), .din_a_o(din_a[g]), .din_b_o(din_b[g]),
      .we_a_o(we_a[g]), .we_b_o(we_b[g]), .dout_a_i(dout_a[g]), .dout_b_i(dout_b[g]));
  end

  assign dout_a[0] = pa[0];
  assign dout_b[0] = pb[0];
  assign dout_a[1] = qa[1];
  assign dout_b[1] = qb[1];

  always @(posedge clk)
    for (int d = 0; d < 2; d++) begin
      if (ld) for (int j = 0; j < 256; j++) mem[d][j] <= init[j];
      else begin
        if (we_a[d]) mem[d][addr_a[d]] <= din_a[d];
        if (we_b[d]) mem[d][addr_b[d]] <= din_b[d];
      end
      pa[d] <= mem[d][addr_a[d]];
      pb[d] <= mem[d][addr_b[d]];
      qa[d] <= pa[d];
      qb[d] <= pb[d];
    end

  always @(negedge clk)
    for (int d = 0; d < 2; d++) begin
      bc[d] += int'(busy[d]);
      dc[d] += int'(done[d]);
      if (we_a[d] || we_b[d]) begin
        wc[d]++;
        if (!(we_a[d] && we_b[d]) || addr_a[d] == addr_b[d]) bad[d]++;
      end
    end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rv(input int j, input int k);
    int r = 0;
    for (int b = 0; b < k; b++) if (((j >> b) & 1) == 1) r |= 1 << (k - 1 - b);
    return r;
  endfunction

  task automatic load(input bit ident);
    for (int j = 0; j < 256; j++) init[j] = ident ? DW'(j) : DW'($urandom);
    @(posedge clk) #1 ld = 1;
    @(posedge clk) #1 ld = 0;
  endtask

  task automatic run(input int sz, input bit ident, input bit poke);
    int k, n, p, t, nbad;
    int b0[2], d0[2], w0[2], x0[2];
    k = sz > L ? L : sz == 0 ? 1 : sz;
    n = 1 << k;
    p = (n - (1 << ((k + 1) / 2))) / 2;
    load(ident);
    for (int d = 0; d < 2; d++) begin
      b0[d] = bc[d]; d0[d] = dc[d]; w0[d] = wc[d]; x0[d] = bad[d];
    end
    size = 4'(sz);
    start = 1;
    @(posedge clk) #1 start = 0;
    if (poke) begin
      repeat (5) @(posedge clk);
      #1 start = 1;
      size = 4'd3;
      @(posedge clk) #1 start = 0;
    end
    t = 0;
    while ((dc[0] == d0[0] || dc[1] == d0[1]) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("done_timeout", 64'(t >= 3000), 0);
    repeat (4) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("busy_cycles k=%0d lat=%0d", k, d + 1), 64'(bc[d] - b0[d]), 64'(n + p * (3 + d)));
      check("done_pulses", 64'(dc[d] - d0[d]), 1);
      check("write_cycles", 64'(wc[d] - w0[d]), 64'(p));
      check("port_rule", 64'(bad[d] - x0[d]), 0);
      check("size_err", 64'(err[d]), 64'(sz > L || sz == 0));
      nbad = 0;
      for (int j = 0; j < 256; j++)
        if (mem[d][j] !== (j < n ? init[rv(j, k)] : init[j])) nbad++;
      check($sformatf("ram_wrong_words k=%0d lat=%0d", k, d + 1), 64'(nbad), 0);
    end
  endtask

  initial begin
    int w0[2], b0[2], d0[2];
    repeat (2) @(posedge clk);
    #3 rst_n = 0;
    #1;
    for (int d = 0; d < 2; d++)
      check("reset_outs", {busy[d], done[d], err[d], we_a[d], we_b[d], |addr_a[d], |addr_b[d],
                           |din_a[d], |din_b[d]}, 0);
    @(negedge clk) rst_n = 1;
    for (int d = 0; d < 2; d++) begin w0[d] = wc[d]; b0[d] = bc[d]; end
    repeat (20) @(negedge clk);
    for (int d = 0; d < 2; d++) check("idle_quiet", 64'(wc[d] - w0[d] + bc[d] - b0[d]), 0);
    run(3, 1, 0);
    check("k3_ram1", 64'(mem[0][1]), 4);
    check("k3_ram3", 64'(mem[0][3]), 6);
    run(8, 1, 0);
    check("k8_ram1", 64'(mem[1][1]), 128);
    check("k8_ram3", 64'(mem[1][3]), 192);
    run(12, 1, 0);
    run(4, 1, 0);
    check("k4_ram1", 64'(mem[0][1]), 8);
    check("k4_ram3", 64'(mem[1][3]), 12);
    run(8, 0, 1);
    load(1);
    for (int d = 0; d < 2; d++) d0[d] = dc[d];
    size = 4'd8;
    start = 1;
    @(posedge clk) #1 start = 0;
    repeat (3) @(posedge clk);
    #2;
    for (int d = 0; d < 2; d++) check("wait_addr", {we_a[d], addr_a[d], addr_b[d]}, {1'b0, 8'd1, 8'd128});
    rst_n = 0;
    #1;
    for (int d = 0; d < 2; d++) check("abort_outs", {busy[d], done[d], we_a[d], we_b[d], |addr_a[d]}, 0);
    @(negedge clk) rst_n = 1;
    repeat (10) @(negedge clk);
    for (int d = 0; d < 2; d++) check("abort_no_done", 64'(dc[d] - d0[d]), 0);
    run(8, 0, 0);
    run(0, 0, 0);
    for (int r = 0; r < 6; r++) run(int'($urandom_range(0, 15)), 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
